mealy_seq_detector: RTL and testbench

- Parametrised Mealy serial-pattern detector, one bit per cycle; generalises the team's fixed 2-state-bit Mealy FSM.
- Pattern, pattern length and overlap mode are set at elaboration.
- Adds input qualification, synchronous clear, a registered match copy and a saturating match counter.
- Sits on a serial bit stream and feeds match events to downstream control or status logic.

---
 rtl/mealy_seq_detector.sv | 117 +++++++++++
 tb/tb_mealy_seq_detector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_detector.sv
// ============================================================================
// Module   : mealy_seq_detector
// Brief    : Parametrised Mealy serial-pattern detector with qualified input,
//            synchronous clear, registered match copy and saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mealy_seq_detector #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit              OVERLAP = 1'b1,
    parameter int              CNT_W   = 8,
    localparam int             SW      = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             x,
    input  logic             clear,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat,
    output logic [SW-1:0]    state
);

    localparam int NS = 1 << SW;

    // Longest suffix of prefix(k)+xb that is a pattern prefix; a full match
    // falls back to the pattern's own border, or to zero without overlap.
    function automatic int unsigned next_len(input int unsigned k, input bit xb);
        logic [63:0]  pat;
        logic [63:0]  seq;
        logic [63:0]  mask;
        int unsigned  len;
        int unsigned  best;
        pat  = 64'(PATTERN);
        seq  = (k == 0) ? 64'd0 : (pat >> (PAT_W - k));
        seq  = (seq << 1) | {63'd0, xb};
        len  = k + 1;
        best = 0;
        if ((len == PAT_W) && (seq == pat)) begin
            if (OVERLAP) begin
                for (int unsigned m = 1; m < PAT_W; m++) begin
                    mask = (64'd1 << m) - 64'd1;
                    if ((pat & mask) == (pat >> (PAT_W - m)))
                        best = m;
                end
            end
        end else begin
            for (int unsigned m = 1; m <= len; m++) begin
                mask = (64'd1 << m) - 64'd1;
                if ((seq & mask) == (pat >> (PAT_W - m)))
                    best = m;
            end
        end
        return best;
    endfunction

    logic [SW-1:0]    w_nxt0 [NS];
    logic [SW-1:0]    w_nxt1 [NS];
    logic [SW-1:0]    r_state;
    logic [SW-1:0]    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_yq;
    logic             w_y;

    for (genvar k = 0; k < NS; k++) begin : g_tab
        if (k < PAT_W) begin : g_live
            localparam int unsigned c_N0 = next_len(k, 1'b0);
            localparam int unsigned c_N1 = next_len(k, 1'b1);
            assign w_nxt0[k] = SW'(c_N0);
            assign w_nxt1[k] = SW'(c_N1);
        end else begin : g_pad
            assign w_nxt0[k] = '0;
            assign w_nxt1[k] = '0;
        end
    end

    always_comb begin
        w_y         = in_valid & ~clear & (r_state == SW'(PAT_W - 1)) & (x == PATTERN[0]);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (clear) begin
            w_state_nxt = '0;
            w_cnt_nxt   = '0;
        end else begin
            if (in_valid)
                w_state_nxt = x ? w_nxt1[r_state] : w_nxt0[r_state];
            if (w_y && (r_cnt != '1))
                w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_yq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_yq    <= w_y;
        end
    end

    assign y           = w_y;
    assign y_q         = r_yq;
    assign match_count = r_cnt;
    assign cnt_sat     = &r_cnt;
    assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mealy_seq_detector.sv
// ============================================================================
// Module   : tb_mealy_seq_detector
// Brief    : Self-checking bench; three detector configurations against a
//            history-based reference model under directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mealy_seq_detector;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic x;
    logic clear;

    logic       y_a, yq_a, sat_a;
    logic [1:0] st_a;
    logic [7:0] mc_a;
    logic       y_b, yq_b, sat_b;
    logic [1:0] st_b;
    logic [1:0] mc_b;
    logic       y_c, yq_c, sat_c;
    logic [2:0] st_c;
    logic [2:0] mc_c;

    always #5 clk = ~clk;

    mealy_seq_detector u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .clear(clear),
        .y(y_a), .y_q(yq_a), .match_count(mc_a), .cnt_sat(sat_a), .state(st_a)
    );

    mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .clear(clear),
        .y(y_b), .y_q(yq_b), .match_count(mc_b), .cnt_sat(sat_b), .state(st_b)
    );

    mealy_seq_detector #(.PAT_W(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(3)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .clear(clear),
        .y(y_c), .y_q(yq_c), .match_count(mc_c), .cnt_sat(sat_c), .state(st_c)
    );

    // Reference model: accepted-bit history since the last restart point.
    int unsigned pw   [3] = '{4, 4, 5};
    logic [63:0] pat  [3] = '{64'hB, 64'hB, 64'h1B};
    bit          ov   [3] = '{1'b1, 1'b0, 1'b1};
    int unsigned cmax [3] = '{255, 3, 7};
    logic [63:0] hist [3];
    int unsigned hlen [3];
    int unsigned cnt  [3];
    bit          yq_m [3];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] lowmask(input int unsigned m);
        return (64'd1 << m) - 64'd1;
    endfunction

    function automatic int unsigned exp_state(input int i);
        int unsigned best = 0;
        for (int unsigned k = 1; k < pw[i]; k++)
            if (k <= hlen[i] && ((hist[i] & lowmask(k)) == (pat[i] >> (pw[i] - k))))
                best = k;
        return best;
    endfunction

    function automatic int unsigned d_y(input int i);
        case (i)
            0: return 32'(y_a);
            1: return 32'(y_b);
            default: return 32'(y_c);
        endcase
    endfunction
    function automatic int unsigned d_yq(input int i);
        case (i)
            0: return 32'(yq_a);
            1: return 32'(yq_b);
            default: return 32'(yq_c);
        endcase
    endfunction
    function automatic int unsigned d_sat(input int i);
        case (i)
            0: return 32'(sat_a);
            1: return 32'(sat_b);
            default: return 32'(sat_c);
        endcase
    endfunction
    function automatic int unsigned d_st(input int i);
        case (i)
            0: return 32'(st_a);
            1: return 32'(st_b);
            default: return 32'(st_c);
        endcase
    endfunction
    function automatic int unsigned d_mc(input int i);
        case (i)
            0: return 32'(mc_a);
            1: return 32'(mc_b);
            default: return 32'(mc_c);
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '0;
            hlen[i] = 0;
            cnt[i]  = 0;
            yq_m[i] = 1'b0;
        end
    endfunction

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_state[%0d]", tag, i), d_st(i),  exp_state(i));
            chk($sformatf("%s_count[%0d]", tag, i), d_mc(i),  cnt[i]);
            chk($sformatf("%s_yq[%0d]", tag, i),    d_yq(i),  32'(yq_m[i]));
            chk($sformatf("%s_sat[%0d]", tag, i),   d_sat(i), 32'(cnt[i] == cmax[i]));
        end
    endtask

    task automatic step(input bit vi, input bit xi, input bit ci);
        logic [63:0] h2;
        bit          ym;
        @(negedge clk);
        in_valid = vi;
        x        = xi;
        clear    = ci;
        #1;
        chk_regs("pre");
        for (int i = 0; i < 3; i++) begin
            h2 = (hist[i] << 1) | {63'd0, xi};
            ym = vi && !ci && (hlen[i] + 1 >= pw[i]) && ((h2 & lowmask(pw[i])) == pat[i]);
            chk($sformatf("y[%0d]", i), d_y(i), 32'(ym));
            if (ci) begin
                hist[i] = '0;
                hlen[i] = 0;
                cnt[i]  = 0;
                yq_m[i] = 1'b0;
            end else begin
                yq_m[i] = ym;
                if (vi) begin
                    hist[i] = h2;
                    hlen[i] = (hlen[i] < 63) ? hlen[i] + 1 : 63;
                    if (ym) begin
                        if (cnt[i] < cmax[i])
                            cnt[i]++;
                        if (!ov[i]) begin
                            hist[i] = '0;
                            hlen[i] = 0;
                        end
                    end
                end
            end
        end
        @(posedge clk);
    endtask

    // Reset asserted between clock edges must clear everything immediately.
    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int j = n - 1; j >= 0; j--)
            step(1'b1, bits[j], 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = 1'b0;
        clear    = 1'b0;
        model_reset();
        #3;
        chk_regs("init");
        @(negedge clk);
        rst_n = 1'b1;

        send(32'b1011011, 7);
        async_reset();

        send(32'b10, 2);
        for (int j = 0; j < 3; j++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        send(32'b11, 2);
        async_reset();

        send(32'b101, 3);
        step(1'b1, 1'b1, 1'b1);
        send(32'b10, 2);
        async_reset();

        send(32'b11011011, 8);
        send(32'b1011011011011011, 16);
        async_reset();

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0)
                async_reset();
            else
                step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
